// File: rtl/rotary_pkg.sv
// rotary_pkg -- shared definitions for the rotary shaft decoder.
//   DEBOUNCE_DEFAULT : default stable-cycle count for the input filters.
//   rot_state_t      : detent tracking FSM states.
package rotary_pkg;

  localparam int DEBOUNCE_DEFAULT = 1000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_A_FIRST = 3'd1,
    ST_B_FIRST = 3'd2,
    ST_DETENT  = 3'd3,
    ST_RESYNC  = 3'd4
  } rot_state_t;

endpackage

// File: rtl/rotary_decoder_debounce_filter.sv
// debounce_filter -- one quadrature channel: 2-flop synchronizer followed by
// a stable-time filter.
//   clk      : clock
//   rst      : asynchronous active-high reset (filtered value resets to 1)
//   raw      : asynchronous channel input, idle high
//   filtered : debounced channel value
// A clean raw edge reaches filtered exactly 2 + DEBOUNCE_CYCLES cycles later.
module debounce_filter
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filtered
);

  // The counter is compared against N-1 so that the filtered value moves on
  // the N-th consecutive mismatching cycle.
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic        sync1_reg;
  logic        sync2_reg;
  logic        filt_reg;
  logic [15:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      filt_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg == filt_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        filt_reg <= sync2_reg;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  assign filtered = filt_reg;

endmodule

// File: rtl/rotary_decoder.sv
// rotary_decoder -- quadrature rotary shaft decoder with per-channel debounce.
//   clk                : clock
//   rst                : asynchronous active-high reset
//   rot_a, rot_b       : raw quadrature channels, idle high
//   rotation_event     : high while the shaft sits in a valid detent-low region
//   rotation_direction : direction of the last detent, 1 = CW (A fell first)
//   detent_pulse       : one-cycle strobe when rotation_event rises
//   position           : 8-bit two's complement detent count, present only
//                        when macro ROTARY_POSITION_EN is defined
module rotary_decoder
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rot_a,
  input  logic       rot_b,
  output logic       rotation_event,
  output logic       rotation_direction,
  output logic       detent_pulse
`ifdef ROTARY_POSITION_EN
  ,output logic [7:0] position
`endif
);

  // Channel index 1 = A, 0 = B, so {filt[1], filt[0]} reads as (A,B).
  logic [1:0] raw_vec;
  logic [1:0] filt_vec;

  assign raw_vec = {rot_a, rot_b};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .raw     (raw_vec[gi]),
        .filtered(filt_vec[gi])
      );
    end
  endgenerate

  rot_state_t state_reg;
  rot_state_t state_next;
  logic       event_reg;
  logic       pulse_reg;
  logic       dir_reg;
  logic       dir_next;
  logic       enter_detent;

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    case (state_reg)
      ST_IDLE: begin
        case (filt_vec)
          2'b01:   state_next = ST_A_FIRST;
          2'b10:   state_next = ST_B_FIRST;
          2'b00:   state_next = ST_RESYNC;  // both fell together: no direction
          default: state_next = ST_IDLE;
        endcase
      end
      ST_A_FIRST: begin
        if (filt_vec == 2'b00) begin
          state_next = ST_DETENT;
          dir_next   = 1'b1;
        end else if (filt_vec == 2'b11) begin
          state_next = ST_IDLE;
        end
      end
      ST_B_FIRST: begin
        if (filt_vec == 2'b00) begin
          state_next = ST_DETENT;
          dir_next   = 1'b0;
        end else if (filt_vec == 2'b11) begin
          state_next = ST_IDLE;
        end
      end
      ST_DETENT, ST_RESYNC: begin
        if (filt_vec == 2'b11) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign enter_detent = (state_next == ST_DETENT) && (state_reg != ST_DETENT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      event_reg <= 1'b0;
      pulse_reg <= 1'b0;
      dir_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      event_reg <= (state_next == ST_DETENT);
      pulse_reg <= enter_detent;
      dir_reg   <= dir_next;
    end
  end

  assign rotation_event     = event_reg;
  assign rotation_direction = dir_reg;
  assign detent_pulse       = pulse_reg;

`ifdef ROTARY_POSITION_EN
  logic [7:0] pos_reg;

  // Counts on the same edge the pulse is raised; natural 8-bit wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_reg <= '0;
    end else if (enter_detent) begin
      pos_reg <= pos_reg + (dir_next ? 8'h01 : 8'hFF);
    end
  end

  assign position = pos_reg;
`endif

endmodule

// File: tb/tb_rotary_decoder.sv
// tb_rotary_decoder -- self-checking bench for rotary_decoder with
// DEBOUNCE_CYCLES = 4. Shaft motions are taken from a vector table; the
// expected outcome of each motion is queued when it is driven and compared
// after the motion has settled. Position checks exist when ROTARY_POSITION_EN
// is defined.
module tb_rotary_decoder;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rot_a = 1'b1;
  logic rot_b = 1'b1;
  logic rotation_event;
  logic rotation_direction;
  logic detent_pulse;
`ifdef ROTARY_POSITION_EN
  logic [7:0] position;
`endif

  always #5 clk = ~clk;

  rotary_decoder #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk               (clk),
    .rst               (rst),
    .rot_a             (rot_a),
    .rot_b             (rot_b),
    .rotation_event    (rotation_event),
    .rotation_direction(rotation_direction),
    .detent_pulse      (detent_pulse)
`ifdef ROTARY_POSITION_EN
    ,.position         (position)
`endif
  );

  // Motion kinds
  localparam int K_CW     = 0;
  localparam int K_CCW    = 1;
  localparam int K_GLITCH = 2;
  localparam int K_SIMUL  = 3;
  localparam int K_BOUNCE = 4;

  typedef struct {
    int kind;
    int exp_pulses;
    int exp_event_cycles;
    int exp_dir;
    int exp_pos_delta;
  } vec_t;

  typedef struct {
    int idx;
    int exp_pulses;
    int exp_event_cycles;
    int exp_dir;
    int exp_pos;
  } sb_t;

  int total = 0;
  int bad = 0;

  // Output monitor, sampled on the falling edge.
  int   pulse_total = 0;
  int   event_total = 0;
  int   edge_bad = 0;
  logic prev_event = 1'b0;

  always @(negedge clk) begin
    if (detent_pulse) pulse_total++;
    if (rotation_event) event_total++;
    if (detent_pulse !== (rotation_event && !prev_event)) edge_bad++;
    prev_event = rotation_event;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_motion(input int kind);
    case (kind)
      K_CW: begin
        rot_a = 1'b0; wait_cyc(20);
        rot_b = 1'b0; wait_cyc(20);
        rot_a = 1'b1; wait_cyc(20);
        rot_b = 1'b1; wait_cyc(20);
      end
      K_CCW: begin
        rot_b = 1'b0; wait_cyc(20);
        rot_a = 1'b0; wait_cyc(20);
        rot_b = 1'b1; wait_cyc(20);
        rot_a = 1'b1; wait_cyc(20);
      end
      K_GLITCH: begin
        rot_a = 1'b0; wait_cyc(DB - 1);
        rot_a = 1'b1; wait_cyc(20);
      end
      K_SIMUL: begin
        rot_a = 1'b0; rot_b = 1'b0; wait_cyc(20);
        rot_a = 1'b1; rot_b = 1'b1; wait_cyc(20);
      end
      default: begin
        rot_a = 1'b0; wait_cyc(20);
        rot_a = 1'b1; wait_cyc(20);
      end
    endcase
  endtask

  vec_t vecs[8];
  sb_t  sb_q[$];

  initial begin
    int exp_pos;
    int p0, e0;
    sb_t s;

    // CW / CCW steps hold the detent region for 40 cycles (B fall to B rise).
    vecs[0] = '{K_CW,     1, 40, 1,  1};
    vecs[1] = '{K_CCW,    1, 40, 0, -1};
    vecs[2] = '{K_GLITCH, 0,  0, 0,  0};
    vecs[3] = '{K_SIMUL,  0,  0, 0,  0};
    vecs[4] = '{K_CW,     1, 40, 1,  1};
    vecs[5] = '{K_BOUNCE, 0,  0, 1,  0};
    vecs[6] = '{K_SIMUL,  0,  0, 1,  0};
    vecs[7] = '{K_CCW,    1, 40, 0, -1};

    // Reset state
    wait_cyc(3);
    check("reset_event", int'(rotation_event), 0);
    check("reset_pulse", int'(detent_pulse), 0);
    check("reset_dir", int'(rotation_direction), 0);
`ifdef ROTARY_POSITION_EN
    check("reset_pos", int'(position), 0);
`endif
    rst = 1'b0;
    wait_cyc(10);

    // Exact latency of a CW step: event rises 7 cycles after B falls.
    rot_a = 1'b0; wait_cyc(20);
    rot_b = 1'b0;
    wait_cyc(6);
    check("lat_event_early", int'(rotation_event), 0);
    wait_cyc(1);
    check("lat_event_rise", int'(rotation_event), 1);
    check("lat_pulse_rise", int'(detent_pulse), 1);
    check("lat_dir", int'(rotation_direction), 1);
    wait_cyc(1);
    check("lat_pulse_single", int'(detent_pulse), 0);
    wait_cyc(12);
    rot_a = 1'b1; wait_cyc(20);
    rot_b = 1'b1;
    wait_cyc(6);
    check("lat_event_hold", int'(rotation_event), 1);
    wait_cyc(1);
    check("lat_event_fall", int'(rotation_event), 0);
    wait_cyc(20);
    exp_pos = 1;
    $display("latency step done dir=%0d", rotation_direction);

    // Table-driven motions with scoreboard
    for (int i = 0; i < 8; i++) begin
      p0 = pulse_total;
      e0 = event_total;
      exp_pos = (exp_pos + vecs[i].exp_pos_delta) & 255;
      sb_q.push_back('{i, vecs[i].exp_pulses, vecs[i].exp_event_cycles,
                       vecs[i].exp_dir, exp_pos});
      drive_motion(vecs[i].kind);
      s = sb_q.pop_front();
      check($sformatf("v%0d_pulses", s.idx), pulse_total - p0, s.exp_pulses);
      check($sformatf("v%0d_event_cycles", s.idx), event_total - e0, s.exp_event_cycles);
      check($sformatf("v%0d_dir", s.idx), int'(rotation_direction), s.exp_dir);
`ifdef ROTARY_POSITION_EN
      check($sformatf("v%0d_pos", s.idx), int'(position), s.exp_pos);
`endif
      $display("vector %0d kind=%0d pulses=%0d event_cycles=%0d dir=%0d",
               s.idx, vecs[s.idx].kind, pulse_total - p0, event_total - e0,
               rotation_direction);
    end

    // Reset inside DETENT: outputs drop immediately, then RESYNC with no event.
    rot_a = 1'b0; wait_cyc(20);
    rot_b = 1'b0; wait_cyc(12);
    check("mid_event_before_rst", int'(rotation_event), 1);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_event", int'(rotation_event), 0);
    check("mid_rst_pulse", int'(detent_pulse), 0);
    check("mid_rst_dir", int'(rotation_direction), 0);
`ifdef ROTARY_POSITION_EN
    check("mid_rst_pos", int'(position), 0);
`endif
    wait_cyc(3);
    rst = 1'b0;
    p0 = pulse_total;
    e0 = event_total;
    wait_cyc(30);
    rot_a = 1'b1; wait_cyc(20);
    rot_b = 1'b1; wait_cyc(20);
    check("post_rst_pulses", pulse_total - p0, 0);
    check("post_rst_event_cycles", event_total - e0, 0);
    p0 = pulse_total;
    drive_motion(K_CW);
    check("post_rst_cw_pulses", pulse_total - p0, 1);
    check("post_rst_cw_dir", int'(rotation_direction), 1);
    $display("reset-in-detent sequence done");

`ifdef ROTARY_POSITION_EN
    // Position wrap: 128 CW steps from reset lands on 0x80.
    rst = 1'b1; wait_cyc(2);
    rst = 1'b0; wait_cyc(5);
    p0 = pulse_total;
    for (int i = 0; i < 128; i++) drive_motion(K_CW);
    check("wrap_pulses", pulse_total - p0, 128);
    check("wrap_pos", int'(position), 128);
    drive_motion(K_CCW);
    check("wrap_back_pos", int'(position), 127);
    $display("wrap sequence done pos=%0d", position);
`endif

    check("pulse_matches_event_rise", edge_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
